// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive buffer sitting directly behind the UART receiver. Every completed
// frame (rx_valid/rx_data/rx_err) is stored together with its error flags in
// a 16550-style receive FIFO. In holding-register mode (cfg_fifo_en = 0) the
// buffer behaves as the single 16450 receive holding register.
//
// Ports
//   clk, srst          clock and synchronous active-high reset
//   rx_valid           one-cycle frame-complete pulse from the receiver
//   rx_data, rx_err    received character and its {parity, frame, break} flags
//   char_tick          one pulse per character time (timeout base)
//   cfg_fifo_en        1 = FIFO mode (DEPTH entries), 0 = holding mode (1 entry)
//   cfg_trig_level     trigger level select: 1 / 4 / 8 / 14 entries
//   fifo_clear         flush request
//   rd_en              pop the head entry (RBR read)
//   lsr_rd             LSR read, clears the sticky overrun flag
//   rd_data, rd_err    head entry, forced to zero while empty
//   data_ready         buffer non-empty
//   overrun_err        sticky overrun flag
//   fifo_err           some stored entry carries an error (FIFO mode only)
//   trig_reached       fill level at or above the trigger level
//   timeout_int        character timeout pending (FIFO mode only)
//   count              number of stored entries
// ---------------------------------------------------------------------------

package uart_pkg;

    typedef struct packed {
        logic parity_err;
        logic frame_err;
        logic break_int;
    } rx_err_s;

    // True when any error flag of an entry is set.
    function automatic logic any_err(input rx_err_s e);
        return e.parity_err | e.frame_err | e.break_int;
    endfunction

endpackage

module uart_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    input  uart_pkg::rx_err_s          rx_err,
    input  logic                       char_tick,
    input  logic                       cfg_fifo_en,
    input  logic [1:0]                 cfg_trig_level,
    input  logic                       fifo_clear,
    input  logic                       rd_en,
    input  logic                       lsr_rd,
    output logic [7:0]                 rd_data,
    output uart_pkg::rx_err_s          rd_err,
    output logic                       data_ready,
    output logic                       overrun_err,
    output logic                       fifo_err,
    output logic                       trig_reached,
    output logic                       timeout_int,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Timeout counter saturates at four character times.
    localparam logic [2:0] TMO_MAX = 3'd4;

    // Storage and state registers
    logic [10:0]   mem_r [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] err_count_r;
    logic [2:0]    tmo_cnt_r;
    logic          overrun_r;
    logic          fifo_en_q_r;

    // Next-state and decode signals
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [CW-1:0] count_nxt_s;
    logic [CW-1:0] err_count_nxt_s;
    logic [2:0]    tmo_cnt_nxt_s;
    logic          ovr_set_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;

    logic [CW-1:0] cap_s;
    logic          empty_s;
    logic          full_s;
    logic          flush_s;
    logic          pop_s;
    logic          push_acc_s;
    logic          overwrite_s;
    logic          err_inc_s;
    logic          err_dec_s;
    logic [10:0]   head_s;
    uart_pkg::rx_err_s head_err_s;
    logic [CW-1:0] trig_thr_s;

    // Capacity, flush and handshake decode
    always_comb begin
        cap_s      = cfg_fifo_en ? CW'(DEPTH) : CW'(1);
        empty_s    = (count_r == CW'(0));
        // >= keeps the full test safe in the mode-switch cycle, which flushes anyway.
        full_s     = (count_r >= cap_s);
        // A mode change is detected against last cycle's mode and flushes the buffer.
        flush_s    = fifo_clear | (cfg_fifo_en != fifo_en_q_r);
        pop_s      = rd_en & ~empty_s;
        head_s     = mem_r[rd_ptr_r];
        head_err_s = uart_pkg::rx_err_s'(head_s[10:8]);
    end

    // Next-state logic for pointers, counts, timeout and overrun set
    always_comb begin
        rd_ptr_nxt_s    = rd_ptr_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        count_nxt_s     = count_r;
        err_count_nxt_s = err_count_r;
        tmo_cnt_nxt_s   = tmo_cnt_r;
        ovr_set_s       = 1'b0;
        mem_we_s        = 1'b0;
        mem_waddr_s     = wr_ptr_r;
        push_acc_s      = 1'b0;
        overwrite_s     = 1'b0;
        err_inc_s       = 1'b0;
        err_dec_s       = 1'b0;

        if (flush_s) begin
            rd_ptr_nxt_s    = {AW{1'b0}};
            wr_ptr_nxt_s    = {AW{1'b0}};
            count_nxt_s     = {CW{1'b0}};
            err_count_nxt_s = {CW{1'b0}};
            tmo_cnt_nxt_s   = 3'd0;
        end else begin
            // A pop in the same cycle frees the slot, so a full buffer still accepts.
            if (rx_valid && (!full_s || pop_s)) begin
                push_acc_s   = 1'b1;
                mem_we_s     = 1'b1;
                mem_waddr_s  = wr_ptr_r;
                wr_ptr_nxt_s = wr_ptr_r + AW'(1);
            end else if (rx_valid && !cfg_fifo_en) begin
                // Holding mode: the single stored entry sits at the read pointer.
                overwrite_s  = 1'b1;
                ovr_set_s    = 1'b1;
                mem_we_s     = 1'b1;
                mem_waddr_s  = rd_ptr_r;
            end else if (rx_valid) begin
                // FIFO mode overrun: the character is dropped.
                ovr_set_s    = 1'b1;
            end else begin
                ovr_set_s    = 1'b0;
            end

            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end

            case ({push_acc_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase

            // An overwrite replaces the head entry, so its flags leave and the new ones arrive.
            err_inc_s = (push_acc_s | overwrite_s) & uart_pkg::any_err(rx_err);
            err_dec_s = (pop_s | overwrite_s) & uart_pkg::any_err(head_err_s);
            err_count_nxt_s = err_count_r + CW'(err_inc_s) - CW'(err_dec_s);

            if (rx_valid || pop_s || empty_s) begin
                tmo_cnt_nxt_s = 3'd0;
            end else if (char_tick && (tmo_cnt_r < TMO_MAX)) begin
                tmo_cnt_nxt_s = tmo_cnt_r + 3'd1;
            end else begin
                tmo_cnt_nxt_s = tmo_cnt_r;
            end
        end
    end

    // State register update with synchronous reset
    always_ff @(posedge clk) begin
        if (srst) begin
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            err_count_r <= {CW{1'b0}};
            tmo_cnt_r   <= 3'd0;
            overrun_r   <= 1'b0;
            // Track the live mode so leaving reset does not look like a mode change.
            fifo_en_q_r <= cfg_fifo_en;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            err_count_r <= err_count_nxt_s;
            tmo_cnt_r   <= tmo_cnt_nxt_s;
            fifo_en_q_r <= cfg_fifo_en;
            // A new overrun wins over a same-cycle LSR read.
            if (ovr_set_s) begin
                overrun_r <= 1'b1;
            end else if (lsr_rd) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Entry storage write port; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we_s && !srst) begin
            mem_r[mem_waddr_s] <= {rx_err, rx_data};
        end
    end

    // Trigger threshold decode
    always_comb begin
        case (cfg_trig_level)
            2'b00:   trig_thr_s = CW'(1);
            2'b01:   trig_thr_s = CW'(4);
            2'b10:   trig_thr_s = CW'(8);
            2'b11:   trig_thr_s = CW'(14);
            default: trig_thr_s = CW'(1);
        endcase
    end

    // Status and head-entry outputs, all derived from registered state
    always_comb begin
        count       = count_r;
        data_ready  = ~empty_s;
        overrun_err = overrun_r;
        fifo_err    = cfg_fifo_en & (err_count_r != {CW{1'b0}});
        timeout_int = cfg_fifo_en & (tmo_cnt_r == TMO_MAX) & ~empty_s;
        if (cfg_fifo_en) begin
            trig_reached = (count_r >= trig_thr_s);
        end else begin
            trig_reached = ~empty_s;
        end
        if (empty_s) begin
            rd_data = 8'h00;
            rd_err  = uart_pkg::rx_err_s'(3'b000);
        end else begin
            rd_data = head_s[7:0];
            rd_err  = head_err_s;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo. Directed sequences cover the main
// receive-buffer scenarios, followed by a randomized phase. A queue-based
// model of the buffer predicts every output after each clock.
// ---------------------------------------------------------------------------

module tb_uart_rx_fifo;

    logic              clk = 1'b0;
    logic              srst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    uart_pkg::rx_err_s rx_err;
    logic              char_tick;
    logic              cfg_fifo_en;
    logic [1:0]        cfg_trig_level;
    logic              fifo_clear;
    logic              rd_en;
    logic              lsr_rd;
    logic [7:0]        rd_data;
    uart_pkg::rx_err_s rd_err;
    logic              data_ready;
    logic              overrun_err;
    logic              fifo_err;
    logic              trig_reached;
    logic              timeout_int;
    logic [4:0]        count;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [10:0] mq[$];
    int          m_tmo;
    bit          m_ovr;
    bit          m_prev_en;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk(clk), .srst(srst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .char_tick(char_tick), .cfg_fifo_en(cfg_fifo_en),
        .cfg_trig_level(cfg_trig_level), .fifo_clear(fifo_clear), .rd_en(rd_en),
        .lsr_rd(lsr_rd), .rd_data(rd_data), .rd_err(rd_err),
        .data_ready(data_ready), .overrun_err(overrun_err), .fifo_err(fifo_err),
        .trig_reached(trig_reached), .timeout_int(timeout_int), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Apply the buffer rules to the inputs sampled at this clock edge.
    task automatic model_update();
        int sz;
        int cap;
        bit pop;
        bit set_o;
        set_o = 1'b0;
        if (srst) begin
            mq.delete();
            m_ovr = 1'b0;
            m_tmo = 0;
        end else begin
            if (fifo_clear || (cfg_fifo_en != m_prev_en)) begin
                mq.delete();
                m_tmo = 0;
            end else begin
                sz  = mq.size();
                cap = cfg_fifo_en ? 16 : 1;
                pop = rd_en && (sz > 0);
                if (rx_valid || pop || sz == 0) m_tmo = 0;
                else if (char_tick && m_tmo < 4) m_tmo++;
                if (pop) void'(mq.pop_front());
                if (rx_valid) begin
                    if (mq.size() < cap) begin
                        mq.push_back({rx_err, rx_data});
                    end else begin
                        set_o = 1'b1;
                        if (!cfg_fifo_en) mq[0] = {rx_err, rx_data};
                    end
                end
            end
            if (set_o) m_ovr = 1'b1;
            else if (lsr_rd) m_ovr = 1'b0;
        end
        m_prev_en = cfg_fifo_en;
    endtask

    task automatic check_outputs();
        int nerr;
        int thr;
        logic [7:0] e_data;
        logic [2:0] e_err;
        nerr = 0;
        foreach (mq[i]) if (mq[i][10:8] != 3'b000) nerr++;
        case (cfg_trig_level)
            2'b00: thr = 1;
            2'b01: thr = 4;
            2'b10: thr = 8;
            default: thr = 14;
        endcase
        e_data = (mq.size() > 0) ? mq[0][7:0] : 8'h00;
        e_err  = (mq.size() > 0) ? mq[0][10:8] : 3'b000;
        check_val("count", 32'(count), 32'(mq.size()));
        check_val("data_ready", 32'(data_ready), 32'(mq.size() > 0));
        check_val("rd_data", 32'(rd_data), 32'(e_data));
        check_val("rd_err", 32'(rd_err), 32'(e_err));
        check_val("overrun_err", 32'(overrun_err), 32'(m_ovr));
        check_val("fifo_err", 32'(fifo_err), 32'(cfg_fifo_en && nerr > 0));
        check_val("trig_reached", 32'(trig_reached),
                  32'(cfg_fifo_en ? (mq.size() >= thr) : (mq.size() > 0)));
        check_val("timeout_int", 32'(timeout_int),
                  32'(cfg_fifo_en && m_tmo == 4 && mq.size() > 0));
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] e,
                       input logic r, input logic l, input logic c, input logic t);
        rx_valid   = v;
        rx_data    = d;
        rx_err     = uart_pkg::rx_err_s'(e);
        rd_en      = r;
        lsr_rd     = l;
        fifo_clear = c;
        char_tick  = t;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        cyc(1'b1, d, e, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int wp;
        int rp;
        srst = 1'b1;
        cfg_fifo_en = 1'b1;
        cfg_trig_level = 2'b01;
        m_prev_en = 1'b1;
        m_ovr = 1'b0;
        m_tmo = 0;
        @(negedge clk);
        idle();
        check_val("reset_count", 32'(count), 32'd0);
        check_val("reset_ready", 32'(data_ready), 32'd0);
        srst = 1'b0;

        // Trigger level and ordering
        for (int i = 0; i < 4; i++) begin
            check_val("trig_before", 32'(trig_reached), 32'd0);
            push(8'h41 + 8'(i), 3'b000);
        end
        check_val("trig_after4", 32'(trig_reached), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_val("pop_order", 32'(rd_data), 32'h41 + 32'(i));
            pop();
        end
        check_val("empty_data", 32'(rd_data), 32'd0);
        check_val("empty_ready", 32'(data_ready), 32'd0);

        // FIFO overrun
        for (int i = 0; i < 16; i++) push(8'(i), 3'b000);
        push(8'hAA, 3'b000);
        check_val("ovr_set", 32'(overrun_err), 32'd1);
        check_val("ovr_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_val("ovr_pop", 32'(rd_data), 32'(i));
            pop();
        end
        cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        check_val("ovr_clear", 32'(overrun_err), 32'd0);

        // Error tracking
        push(8'h10, 3'b000);
        push(8'h11, 3'b100);
        push(8'h12, 3'b000);
        check_val("ferr_set", 32'(fifo_err), 32'd1);
        pop();
        check_val("head_parity", 32'(rd_err.parity_err), 32'd1);
        pop();
        check_val("ferr_clear", 32'(fifo_err), 32'd0);
        pop();

        // Holding mode
        cfg_fifo_en = 1'b0;
        idle();
        push(8'h55, 3'b000);
        push(8'h66, 3'b010);
        check_val("hold_ovr", 32'(overrun_err), 32'd1);
        check_val("hold_data", 32'(rd_data), 32'h66);
        check_val("hold_ferr", 32'(fifo_err), 32'd0);
        cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h77, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("hold_nopovr", 32'(overrun_err), 32'd0);
        check_val("hold_data2", 32'(rd_data), 32'h77);
        pop();

        // Character timeout
        cfg_fifo_en = 1'b1;
        idle();
        push(8'h21, 3'b000);
        push(8'h22, 3'b000);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tmo_set", 32'(timeout_int), 32'd1);
        pop();
        check_val("tmo_clear", 32'(timeout_int), 32'd0);
        cyc(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        check_val("tmo_restart", 32'(timeout_int), 32'd0);
        pop();

        // Flush paths and reset mid-stream
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 3'b001);
        cyc(1'b1, 8'h99, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("clr_count", 32'(count), 32'd0);
        push(8'h31, 3'b000);
        push(8'h32, 3'b000);
        cfg_fifo_en = 1'b0;
        idle();
        check_val("mode_flush", 32'(count), 32'd0);
        cfg_fifo_en = 1'b1;
        idle();
        for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 3'b100);
        srst = 1'b1;
        push(8'h50, 3'b000);
        srst = 1'b0;
        check_val("srst_count", 32'(count), 32'd0);
        check_val("srst_ready", 32'(data_ready), 32'd0);
        check_val("srst_ferr", 32'(fifo_err), 32'd0);

        // Randomized phase with per-block traffic bias
        wp = 40;
        rp = 40;
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 0) begin
                wp = $urandom_range(10, 80);
                rp = $urandom_range(5, 70);
                cfg_trig_level = 2'($urandom_range(0, 3));
            end
            srst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 299) == 0) cfg_fifo_en = ~cfg_fifo_en;
            cyc($urandom_range(0, 99) < wp,
                8'($urandom),
                ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                $urandom_range(0, 99) < rp,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 99) == 0,
                $urandom_range(0, 2) == 0);
        end
        srst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
